div_ctrl: RTL and testbench

- Multi-cycle controller and datapath for the RV32M divide instructions DIV, DIVU, REM and REMU.
- It sits beside the ex stage. The decode stage issues a divide with register write disabled and a jump target of pc+4.
- ex pulses start_i with latched operands. This block holds the pipeline via busy_o while it runs a 32-iteration restoring division.
- On completion it performs the single deferred register write-back.

---
 rtl/div_ctrl_pkg.sv | 18 +
 rtl/div_ctrl.sv | 173 +++++++++++++++++
 tb/tb_div_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared constants for the RV32M divide controller: funct3 opcodes and FSM states.
package div_ctrl_pkg;

  // funct3 encodings of the divide instructions
  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  // Controller states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_CALC  = 2'd2,
    S_END   = 2'd3
  } state_e;

endpackage

// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU with deferred register write-back.
// Holds the pipeline via busy_o and emits a single write-back pulse on completion.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      reg_waddr_i,
  input  logic            abort_i,
  output logic            busy_o,
  output logic            ready_o,
  output logic [XLEN-1:0] result_o,
  output logic            reg_we_o,
  output logic [4:0]      reg_waddr_o
);

  // One restoring step: shift {rem,quot} left, subtract the divisor if it fits.
  // The shifted remainder needs XLEN+1 bits; one extra bit holds the borrow.
  function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                 input logic [XLEN-1:0] quot,
                                                 input logic [XLEN-1:0] dvs);
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;
    shifted = {rem, quot[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, dvs};
    if (diff[XLEN+1]) begin
      // Borrow means the shifted remainder is below the divisor, so its top bit is zero.
      return {shifted[XLEN-1:0], quot[XLEN-2:0], 1'b0};
    end
    return {diff[XLEN-1:0], quot[XLEN-2:0], 1'b1};
  endfunction

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   dvd_q, dvd_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quot_q, quot_d;
  logic [XLEN-1:0]   dvs_abs_q, dvs_abs_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        waddr_q, waddr_d;

  logic              is_signed;
  logic              is_rem;
  logic              neg_quot;
  logic              neg_rem;
  logic [2*XLEN-1:0] step;
  logic [XLEN-1:0]   step_rem;
  logic [XLEN-1:0]   step_quot;

  assign is_signed = (op_q == INST_DIV) || (op_q == INST_REM);
  assign is_rem    = (op_q == INST_REM) || (op_q == INST_REMU);
  assign neg_quot  = is_signed && (dvd_q[XLEN-1] ^ dvs_q[XLEN-1]);
  assign neg_rem   = is_signed && dvd_q[XLEN-1];
  assign step      = div_step(rem_q, quot_q, dvs_abs_q);
  assign step_rem  = step[2*XLEN-1:XLEN];
  assign step_quot = step[XLEN-1:0];

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rd_d      = rd_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    dvs_abs_d = dvs_abs_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b0;
    result_d  = '0;
    waddr_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          op_d    = op_i;
          dvd_d   = dividend_i;
          dvs_d   = divisor_i;
          rd_d    = reg_waddr_i;
          state_d = S_START;
        end
      end
      S_START: begin
        if (dvs_q == '0) begin
          // Divide by zero: quotient all ones, remainder is the dividend.
          state_d  = S_END;
          ready_d  = 1'b1;
          result_d = is_rem ? dvd_q : '1;
          waddr_d  = rd_q;
        end else begin
          rem_d     = '0;
          quot_d    = (is_signed && dvd_q[XLEN-1]) ? -dvd_q : dvd_q;
          dvs_abs_d = (is_signed && dvs_q[XLEN-1]) ? -dvs_q : dvs_q;
          cnt_d     = '0;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        rem_d  = step_rem;
        quot_d = step_quot;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d  = S_END;
          ready_d  = 1'b1;
          waddr_d  = rd_q;
          if (is_rem) result_d = neg_rem ? -step_rem : step_rem;
          else        result_d = neg_quot ? -step_quot : step_quot;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A flush or interrupt cancels any operation in flight, including a pending write-back.
    if (abort_i && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      ready_d  = 1'b0;
      result_d = '0;
      waddr_d  = '0;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rd_q      <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      dvs_abs_q <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      result_q  <= '0;
      waddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rd_q      <= rd_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      dvs_abs_q <= dvs_abs_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
      waddr_q   <= waddr_d;
    end
  end

  // An abort arriving during END still has to suppress the write-back in that same cycle.
  assign busy_o      = (state_q != S_IDLE);
  assign ready_o     = ready_q & ~abort_i;
  assign reg_we_o    = ready_o;
  assign result_o    = ready_o ? result_q : '0;
  assign reg_waddr_o = ready_o ? waddr_q : '0;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: vector table, scoreboard queue and corner-case sequences.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [4:0]  reg_waddr_i = '0;
  logic        abort_i = 1'b0;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] result_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;

  div_ctrl #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .reg_waddr_i(reg_waddr_i),
    .abort_i(abort_i), .busy_o(busy_o), .ready_o(ready_o), .result_o(result_o),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Independent reference for RV32M division semantics.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb_v;
    sa = a;
    sb_v = b;
    if (b == 32'd0) return (op == INST_REM || op == INST_REMU) ? a : 32'hFFFF_FFFF;
    case (op)
      INST_DIVU: return a / b;
      INST_REMU: return a % b;
      INST_DIV:  return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb_v);
      default:   return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb_v);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a request at a negedge; it is sampled at the following posedge (cycle 0).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit push, input int lat);
    exp_t e;
    op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = rd; start_i = 1'b1;
    if (push) begin
      e.res = model(op, a, b); e.rd = rd; e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  // Wait for ready_o, optionally pulsing a stray start with other operands mid-run.
  task automatic wait_result(input int stray_cyc);
    int   cyc;
    bit   seen;
    exp_t e;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start_i = 1'b0;
        chk("busy_after_start", 32'(busy_o), 32'd1);
      end
      if (ready_o) seen = 1'b1;
      else if (stray_cyc > 0 && cyc == stray_cyc) begin
        start_i = 1'b1; op_i = INST_DIVU; dividend_i = 32'h0000_1234;
        divisor_i = 32'd3; reg_waddr_i = 5'd31;
      end else if (stray_cyc > 0 && cyc == stray_cyc + 1) begin
        start_i = 1'b0;
      end
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: got result %h expected no transaction", result_o);
      return;
    end
    e = sb.pop_front();
    if (!seen) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got no ready_o after %0d cycles expected cycle %0d", cyc, e.lat);
      return;
    end
    $display("txn op=%b a=%h b=%h rd=%0d result=%h cycle=%0d", op_i, dividend_i, divisor_i,
             reg_waddr_o, result_o, cyc);
    chk("latency", 32'(cyc), 32'(e.lat));
    chk("result", result_o, e.res);
    chk("reg_waddr", 32'(reg_waddr_o), 32'(e.rd));
    chk("reg_we", 32'(reg_we_o), 32'd1);
    @(negedge clk);
    chk("ready_one_cycle", 32'(ready_o), 32'd0);
    chk("result_zero_idle", result_o, 32'd0);
  endtask

  initial begin
    int ready_seen;

    vecs[0]  = '{INST_DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         34};
    vecs[1]  = '{INST_REMU, 32'd100,        32'd7,          5'd5,  32'd2,          34};
    vecs[2]  = '{INST_DIV,  32'hFFFF_FFF9,  32'd2,          5'd1,  32'hFFFF_FFFD,  34};
    vecs[3]  = '{INST_REM,  32'hFFFF_FFF9,  32'd2,          5'd2,  32'hFFFF_FFFF,  34};
    vecs[4]  = '{INST_DIV,  32'd7,          32'hFFFF_FFFE,  5'd3,  32'hFFFF_FFFD,  34};
    vecs[5]  = '{INST_DIVU, 32'd5,          32'd0,          5'd4,  32'hFFFF_FFFF,  2};
    vecs[6]  = '{INST_REM,  32'hFFFF_FFF6,  32'd0,          5'd6,  32'hFFFF_FFF6,  2};
    vecs[7]  = '{INST_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd7,  32'h8000_0000,  34};
    vecs[8]  = '{INST_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'd0,          34};
    vecs[9]  = '{INST_DIV,  32'd5,          32'd0,          5'd9,  32'hFFFF_FFFF,  2};
    vecs[10] = '{INST_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd10, 32'hFFFF_FFFF,  34};
    vecs[11] = '{INST_REMU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd11, 32'd0,          34};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_we", 32'(reg_we_o), 32'd0);
    chk("rst_waddr", 32'(reg_waddr_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors, issued back-to-back in the cycle after each END
    for (int i = 0; i < 12; i++) begin
      chk("table_model", model(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, 1'b1, vecs[i].lat);
      wait_result(0);
    end

    // Random operands against the reference model
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'b100 + 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      issue(op, a, b, 5'(i + 12), 1'b1, (b == 32'd0) ? 2 : 34);
      wait_result(0);
    end

    // Stray start in CALC with different operands is ignored
    issue(INST_DIVU, 32'd1000, 32'd9, 5'd20, 1'b1, 34);
    wait_result(5);

    // Abort in the 10th CALC cycle, then a start one cycle later
    issue(INST_DIVU, 32'd1000, 32'd3, 5'd21, 1'b0, 0);
    ready_seen = 0;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start_i = 1'b0;
      if (ready_o) ready_seen++;
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    if (ready_o) ready_seen++;
    chk("abort_busy_low", 32'(busy_o), 32'd0);
    chk("abort_no_ready", 32'(ready_seen), 32'd0);
    issue(INST_REMU, 32'd1000, 32'd7, 5'd22, 1'b1, 34);
    wait_result(0);

    // Abort together with start in IDLE: nothing accepted
    abort_i = 1'b1;
    op_i = INST_DIVU; dividend_i = 32'd8; divisor_i = 32'd2; start_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0; start_i = 1'b0;
    chk("abort_wins_busy", 32'(busy_o), 32'd0);

    // Asynchronous reset mid-CALC: outputs drop at once, no write-back
    issue(INST_DIVU, 32'd5000, 32'd7, 5'd23, 1'b0, 0);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start_i = 1'b0;
    end
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy_o), 32'd0);
    chk("async_rst_we", 32'(reg_we_o), 32'd0);
    chk("async_rst_waddr", 32'(reg_waddr_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ready_seen = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (ready_o || busy_o) ready_seen++;
    end
    chk("rst_no_writeback", 32'(ready_seen), 32'd0);

    // Recovery after reset
    issue(INST_DIV, 32'hFFFF_FF9C, 32'd7, 5'd24, 1'b1, 34);
    wait_result(0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
